// File: rtl/bidir_ram_pkg.sv
// Shared constants and clear-sweep state type for bidir_ram.
package bidir_ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic {
    IDLE,
    CLEAR
  } clear_state_t;

endpackage

// File: rtl/bidir_ram_clear_fsm.sv
// Reset-triggered sweep that zeroes every word, one address per cycle.
// Used by bidir_ram only when BIDIR_RAM_CLEAR_EN is defined.
module bidir_ram_clear_fsm
  import bidir_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  clear_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      clr_we   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          clr_we <= 1'b0;
        end
        CLEAR: begin
          // The last address is still written on this edge; busy drops with it.
          if (clr_addr == '1) begin
            state  <= IDLE;
            busy   <= 1'b0;
            clr_we <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          clr_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bidir_ram.sv
// Single-port synchronous RAM on a shared bidirectional data bus.
// Optional reset clear sweep enabled by defining BIDIR_RAM_CLEAR_EN.
module bidir_ram
  import bidir_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  oe,
  input  logic                  w_r1,
  input  logic                  cs,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata;
  logic                  user_en;

`ifdef BIDIR_RAM_CLEAR_EN
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  bidir_ram_clear_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_fsm (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );
`else
  assign busy = 1'b0;
`endif

  assign user_en = cs && !rst && !busy;

  always_ff @(posedge clk) begin
`ifdef BIDIR_RAM_CLEAR_EN
    if (!rst && clr_we) begin
      mem[clr_addr] <= '0;
    end else
`endif
    if (user_en && w_r1) begin
      mem[address] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (user_en && !w_r1) begin
      rdata <= mem[address];
    end
  end

  // Never drive during writes, so an external writer cannot contend with us.
  assign data = (cs && oe && !w_r1) ? rdata : 'z;

endmodule

// File: tb/tb_bidir_ram.sv
// Directed plus randomized bench for bidir_ram against an array-based memory model.
module tb_bidir_ram;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic          oe;
  logic          w_r1;
  logic          cs;
  logic [DW-1:0] drive;
  logic          drive_en;
  wire  [DW-1:0] data;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] model_rdata;
  bit            rd_known;

  assign data = drive_en ? drive : 'z;

  always #5 clk = ~clk;

  bidir_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .address(address),
    .oe     (oe),
    .w_r1   (w_r1),
    .cs     (cs),
    .data   (data),
    .busy   (busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clocked operation; the bench drives the bus whenever the RAM must not.
  task automatic op(input string tag, input logic c, input logic w, input logic o,
                    input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ram_drives;
    cs = c; w_r1 = w; oe = o; address = a; drive = d;
    ram_drives = c && o && !w;
    drive_en = !ram_drives;
    @(posedge clk);
    if (c) begin
      if (w) begin
        model[a] = d;
        known[a] = 1'b1;
      end else begin
        model_rdata = model[a];
        rd_known    = known[a];
      end
    end
    #1;
    if (ram_drives) begin
      if (rd_known) check({tag, "_rd"}, data, model_rdata);
    end else begin
      check({tag, "_bus"}, data, d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cs = 1'b0; drive_en = 1'b1; drive = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rdata = '0;
    rd_known    = 1'b1;
    cs = 1'b1; oe = 1'b1; w_r1 = 1'b0; drive_en = 1'b0;
    #1;
    check("rst_data", data, '0);
`ifdef BIDIR_RAM_CLEAR_EN
    check_bit("rst_busy", busy, 1'b1);
    cs = 1'b0; drive_en = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == DEPTH / 2) begin
        cs = 1'b1; w_r1 = 1'b1; address = '0; drive = 8'h77;
      end else begin
        cs = 1'b0;
      end
      @(posedge clk);
      #1;
      check_bit("sweep_busy", busy, (k < DEPTH) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      known[i] = 1'b1;
    end
`else
    check_bit("rst_busy", busy, 1'b0);
`endif
    cs = 1'b0; drive_en = 1'b1;
  endtask

  initial begin
    rst = 1'b0; cs = 1'b0; oe = 1'b0; w_r1 = 1'b0; address = '0;
    drive = '0; drive_en = 1'b1; model_rdata = '0; rd_known = 1'b0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    do_reset();

    op("wr_a5", 1'b1, 1'b1, 1'b0, 8'd0, 8'hA5);
    op("rd_a5", 1'b1, 1'b0, 1'b1, 8'd0, 8'h00);
    check("rd_a5_abs", data, 8'hA5);
    op("wr_3c", 1'b1, 1'b1, 1'b1, 8'd1, 8'h3C);
    op("rd_3c", 1'b1, 1'b0, 1'b1, 8'd1, 8'h00);
    check("rd_3c_abs", data, 8'h3C);
    op("rd_a5b", 1'b1, 1'b0, 1'b1, 8'd0, 8'h00);

    op("ts_cs", 1'b0, 1'b0, 1'b1, 8'd0, 8'h5A);
    op("ts_oe", 1'b1, 1'b0, 1'b0, 8'd1, 8'hC3);
    op("ts_wr", 1'b1, 1'b1, 1'b1, 8'd2, 8'h96);

    op("rd_pre", 1'b1, 1'b0, 1'b1, 8'd0, 8'h00);
    do_reset();
    op("rd_post", 1'b1, 1'b0, 1'b1, 8'd0, 8'h00);
`ifndef BIDIR_RAM_CLEAR_EN
    check("retain_a5", data, 8'hA5);
`endif

    op("wr_ff", 1'b1, 1'b1, 1'b0, 8'd255, 8'hFF);
    op("wr_11", 1'b1, 1'b1, 1'b0, 8'd0, 8'h11);
    op("rd_ff", 1'b1, 1'b0, 1'b1, 8'd255, 8'h00);
    check("wrap_ff", data, 8'hFF);
    op("rd_11", 1'b1, 1'b0, 1'b1, 8'd0, 8'h00);
    check("wrap_11", data, 8'h11);

    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(248, 255)) : AW'($urandom_range(0, 15));
      op("rand", ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1,
         $urandom_range(0, 3) != 0, a, DW'($urandom));
    end

`ifdef BIDIR_RAM_CLEAR_EN
    rst = 1'b1; cs = 1'b0; drive_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k < 100; k++) begin
      @(posedge clk);
      #1;
      check_bit("pre_restart_busy", busy, 1'b1);
    end
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      op("clr_rd", 1'b1, 1'b0, 1'b1, AW'(i), 8'h00);
      check("clr_zero", data, 8'h00);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
